// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
// Response-state encoding, load/store width codes and the memory depth.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        IF_RESP = 2'd1,
        D_RESP  = 2'd2
    } resp_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int MEM_WORDS = 64;

    // Halfword accesses need bit 0 clear, word accesses need both low bits clear.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_H, F3_HU: return lo[0];
            F3_W:        return lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Request/response and memory-side signals of the unified memory arbiter.
// MISALIGN_CHECK_EN adds the d_misalign response strobe.
interface unified_mem_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_read;
    logic        d_write;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
`ifdef MISALIGN_CHECK_EN
    logic        d_misalign;
`endif

    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Pipeline stages plus memory block, seen from outside the arbiter.
    modport master (
        output if_req, if_addr, d_read, d_write, d_funct3, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_read, mem_write, mem_funct3, mem_addr, mem_wdata
`ifdef MISALIGN_CHECK_EN
        , input d_misalign
`endif
    );

    modport slave (
        input  if_req, if_addr, d_read, d_write, d_funct3, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_read, mem_write, mem_funct3, mem_addr, mem_wdata
`ifdef MISALIGN_CHECK_EN
        , output d_misalign
`endif
    );

endinterface

// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter between fetch and load/store with fetch aging.
// Optional MISALIGN_CHECK_EN suppresses misaligned data accesses and flags them.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_BASE_WORD = 53,
    parameter int STARVE_LIMIT   = 3
) (
    input logic                  clk,
    input logic                  rst,
    unified_mem_arbiter_if.slave bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    localparam logic [5:0] BASE  = 6'(DATA_BASE_WORD % MEM_WORDS);

    logic        d_req;
    logic        force_if;
    logic        if_gnt;
    logic        d_gnt;
    logic        mis;
    logic        load_gnt;
    logic [5:0]  d_word;

    resp_state_e resp_q, resp_d;
    logic [3:0]  starve_q, starve_d;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;

    assign d_req    = bus.d_read | bus.d_write;
    assign force_if = (starve_q == LIMIT);
    assign if_gnt   = bus.if_req & (~d_req | force_if);
    assign d_gnt    = d_req & ~if_gnt;
    // 6-bit add wraps the data window around the top of memory.
    assign d_word   = BASE + bus.d_addr[7:2];

`ifdef MISALIGN_CHECK_EN
    logic misalign_q;
    assign mis = is_misaligned(bus.d_funct3, bus.d_addr[1:0]);
    logic unused_addr;
    assign unused_addr = ^{bus.if_addr[31:8], bus.if_addr[1:0], bus.d_addr[31:8]};
`else
    assign mis = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{bus.if_addr[31:8], bus.if_addr[1:0], bus.d_addr[31:8], bus.d_addr[1:0]};
`endif

    // A store with d_read also high is still just a store.
    assign load_gnt = d_gnt & bus.d_read & ~bus.d_write & ~mis;

    always_comb begin
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_funct3 = 3'b000;
        bus.mem_addr   = 6'd0;
        if (if_gnt) begin
            bus.mem_read   = 1'b1;
            bus.mem_funct3 = F3_W;
            bus.mem_addr   = bus.if_addr[7:2];
        end else if (d_gnt) begin
            bus.mem_read   = bus.d_read & ~bus.d_write & ~mis;
            bus.mem_write  = bus.d_write & ~mis;
            bus.mem_funct3 = bus.d_funct3;
            bus.mem_addr   = d_word;
        end
    end

    assign bus.mem_wdata = bus.d_wdata;

    always_comb begin
        starve_d = starve_q;
        if (!bus.if_req || if_gnt)
            starve_d = 4'd0;
        else if (starve_q != LIMIT)
            starve_d = starve_q + 4'd1;

        resp_d = NONE;
        if (if_gnt)
            resp_d = IF_RESP;
        else if (load_gnt)
            resp_d = D_RESP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_q     <= NONE;
            starve_q   <= 4'd0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
`ifdef MISALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            resp_q   <= resp_d;
            starve_q <= starve_d;
            if (if_gnt)
                if_rdata_q <= bus.mem_rdata;
            if (load_gnt)
                d_rdata_q <= bus.mem_rdata;
`ifdef MISALIGN_CHECK_EN
            misalign_q <= d_gnt & mis;
`endif
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_rvalid = (resp_q == IF_RESP);
    assign bus.d_rvalid  = (resp_q == D_RESP);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
`ifdef MISALIGN_CHECK_EN
    assign bus.d_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed vectors, a behavioural model checked
// every cycle on the falling edge, and literal checks that pin the model.
module tb_unified_mem_arbiter;

    localparam int BASE  = 53;
    localparam int LIMIT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    unified_mem_arbiter_if bus();

    unified_mem_arbiter #(.DATA_BASE_WORD(BASE), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i == 54) ? 32'd9 : 32'hA500_0000 + 32'(i * 7);
    endfunction

    // Memory block: combinational read, write on the clock edge.
    logic [31:0] mem [64];
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: what each cycle must look like from the rules alone.
    logic [31:0] ref_mem [64];
    int          m_denied;
    logic        m_if_pend, m_d_pend, m_mis_pend;
    logic [31:0] m_if_data, m_d_data;
    int          who, fword, dword;
    logic        d_req, is_load, is_store, mis, e_rd, e_wr;

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = init_word(i);
            ref_mem[i] = init_word(i);
        end
        m_denied = 0; m_if_pend = 0; m_d_pend = 0; m_mis_pend = 0;
        m_if_data = 0; m_d_data = 0;
    end

    always @(negedge clk) begin
        if (rst) begin
            m_denied = 0; m_if_pend = 0; m_d_pend = 0; m_mis_pend = 0;
            m_if_data = 0; m_d_data = 0;
            chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
            chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        end else begin
            d_req    = bus.d_read || bus.d_write;
            is_store = bus.d_write;
            is_load  = bus.d_read && !bus.d_write;
            fword    = int'(bus.if_addr[7:2]);
            dword    = (BASE + int'(bus.d_addr[7:2])) % 64;
`ifdef MISALIGN_CHECK_EN
            mis = d_req && ((((bus.d_funct3 == 3'b001) || (bus.d_funct3 == 3'b101)) && bus.d_addr[0])
                            || ((bus.d_funct3 == 3'b010) && (bus.d_addr[1:0] != 2'b00)));
`else
            mis = 1'b0;
`endif
            if (bus.if_req && d_req) who = (m_denied >= LIMIT) ? 1 : 2;
            else if (bus.if_req)     who = 1;
            else if (d_req)          who = 2;
            else                     who = 0;
            e_rd = (who == 1) || (who == 2 && is_load && !mis);
            e_wr = (who == 2) && is_store && !mis;

            chk("if_gnt", 32'(bus.if_gnt), 32'(who == 1));
            chk("d_gnt", 32'(bus.d_gnt), 32'(who == 2));
            chk("mem_read", 32'(bus.mem_read), 32'(e_rd));
            chk("mem_write", 32'(bus.mem_write), 32'(e_wr));
            chk("mem_wdata", bus.mem_wdata, bus.d_wdata);
            if (who == 1) begin
                chk("mem_addr_if", 32'(bus.mem_addr), 32'(fword));
                chk("mem_f3_if", 32'(bus.mem_funct3), 32'd2);
            end else if (who == 2) begin
                chk("mem_addr_d", 32'(bus.mem_addr), 32'(dword));
                chk("mem_f3_d", 32'(bus.mem_funct3), 32'(bus.d_funct3));
            end
            chk("if_rvalid", 32'(bus.if_rvalid), 32'(m_if_pend));
            chk("d_rvalid", 32'(bus.d_rvalid), 32'(m_d_pend));
            chk("if_rdata", bus.if_rdata, m_if_data);
            chk("d_rdata", bus.d_rdata, m_d_data);
`ifdef MISALIGN_CHECK_EN
            chk("d_misalign", 32'(bus.d_misalign), 32'(m_mis_pend));
`endif
            // State as it will stand after the coming rising edge.
            m_if_pend  = (who == 1);
            m_d_pend   = (who == 2) && is_load && !mis;
            m_mis_pend = (who == 2) && mis;
            if (who == 1) m_if_data = ref_mem[fword];
            if (m_d_pend) m_d_data = ref_mem[dword];
            if (e_wr) ref_mem[dword] = bus.d_wdata;
            if (!bus.if_req || who == 1) m_denied = 0;
            else if (m_denied < LIMIT)   m_denied = m_denied + 1;
        end
    end

    task automatic drive(input logic ifr, input logic [31:0] ifa, input logic dr, input logic dw,
                         input logic [2:0] f3, input logic [31:0] da, input logic [31:0] wd);
        @(posedge clk); #1;
        bus.if_req = ifr; bus.if_addr = ifa;
        bus.d_read = dr; bus.d_write = dw; bus.d_funct3 = f3; bus.d_addr = da; bus.d_wdata = wd;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    endtask

    initial begin
        bus.if_req = 0; bus.if_addr = 0; bus.d_read = 0; bus.d_write = 0;
        bus.d_funct3 = 3'b010; bus.d_addr = 0; bus.d_wdata = 0;
        #1;
        chk("lit_reset_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        chk("lit_reset_d_rdata", bus.d_rdata, 32'd0);
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;

        // Fetch alone at 0x4.
        drive(1'b1, 32'h4, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0); #2;
        chk("lit_fetch_gnt", 32'(bus.if_gnt), 32'd1);
        chk("lit_fetch_addr", 32'(bus.mem_addr), 32'd1);
        idle(); #2;
        chk("lit_fetch_rvalid", 32'(bus.if_rvalid), 32'd1);
        chk("lit_fetch_rdata", bus.if_rdata, init_word(1));

        // Load at 0x4 competing with a fetch at 0x8.
        drive(1'b1, 32'h8, 1'b1, 1'b0, 3'b010, 32'h4, 32'h0); #2;
        chk("lit_load_dgnt", 32'(bus.d_gnt), 32'd1);
        chk("lit_load_ifgnt", 32'(bus.if_gnt), 32'd0);
        chk("lit_load_addr", 32'(bus.mem_addr), 32'd54);
        drive(1'b1, 32'h8, 1'b0, 1'b0, 3'b010, 32'h4, 32'h0); #2;
        chk("lit_load_rvalid", 32'(bus.d_rvalid), 32'd1);
        chk("lit_load_rdata", bus.d_rdata, 32'd9);
        chk("lit_fetch_after_load", 32'(bus.if_gnt), 32'd1);
        idle();

        // Store 34 at 0xC, then load it back.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 3'b010, 32'hC, 32'd34); #2;
        chk("lit_store_wr", 32'(bus.mem_write), 32'd1);
        chk("lit_store_addr", 32'(bus.mem_addr), 32'd56);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 3'b010, 32'hC, 32'd0); #2;
        chk("lit_store_no_rvalid", 32'(bus.d_rvalid), 32'd0);
        idle(); #2;
        chk("lit_reload_rdata", bus.d_rdata, 32'd34);

        // Read+write together is a store; address wrap on both paths.
        drive(1'b0, 32'h0, 1'b1, 1'b1, 3'b010, 32'h10, 32'h55); #2;
        chk("lit_rw_read", 32'(bus.mem_read), 32'd0);
        chk("lit_rw_addr", 32'(bus.mem_addr), 32'd57);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 3'b000, 32'h2C, 32'h0); #2;
        chk("lit_wrap_d", 32'(bus.mem_addr), 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 3'b100, 32'hFC, 32'h0); #2;
        chk("lit_wrap_d_top", 32'(bus.mem_addr), 32'd52);
        drive(1'b1, 32'h1FC, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0); #2;
        chk("lit_wrap_if", 32'(bus.mem_addr), 32'd63);
        idle();

        // Starvation: fetch wins every fourth cycle.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'h20, 1'b1, 1'b0, 3'b010, 32'h4, 32'h0); #2;
            chk("lit_starve_if", 32'(bus.if_gnt), 32'((k % 4) == 3));
        end
        idle();

        // Build up aging, then reset asynchronously in the cycle after a load grant.
        for (int k = 0; k < 3; k++) drive(1'b1, 32'h0, 1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
        idle(); #1;
        chk("lit_pre_rst_rvalid", 32'(bus.d_rvalid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("lit_rst_rvalid", 32'(bus.d_rvalid), 32'd0);
        chk("lit_rst_rdata", bus.d_rdata, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        bus.if_req = 1; bus.if_addr = 32'h0; bus.d_read = 1; bus.d_addr = 32'h4;
        #2;
        chk("lit_post_rst_dgnt", 32'(bus.d_gnt), 32'd1);
        idle();

`ifdef MISALIGN_CHECK_EN
        drive(1'b0, 32'h0, 1'b1, 1'b0, 3'b010, 32'h6, 32'h0); #2;
        chk("lit_mis_gnt", 32'(bus.d_gnt), 32'd1);
        chk("lit_mis_read", 32'(bus.mem_read), 32'd0);
        idle(); #2;
        chk("lit_mis_flag", 32'(bus.d_misalign), 32'd1);
        chk("lit_mis_rvalid", 32'(bus.d_rvalid), 32'd0);
`endif

        idle(); idle();
        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Arbitrates the single-port unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store). Grants one access per cycle.
- Maps byte addresses to 6-bit word indices and registers read data, returning it one cycle after grant.
- Prevents fetch starvation with an aging counter.
- Sits between the pipeline stages and the memory block; its grant signals drive the hazard unit's stall inputs.

Parameters:
- DATA_BASE_WORD, 53, word index where data byte address 0 maps; data word = (DATA_BASE_WORD + d_addr[7:2]) mod 64
- STARVE_LIMIT, 3, consecutive denied fetch cycles before fetch is forced to win; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte PC; word = if_addr[7:2]
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  if_rdata valid (registered)
- if_rdata  out  32  fetched instruction
- d_read  in  1  load request
- d_write  in  1  store request
- d_funct3  in  3  load/store width code, passed to memory
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_gnt  out  1  data access granted this cycle (combinational)
- d_rvalid  out  1  d_rdata valid (registered; loads only)
- d_rdata  out  32  load data
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_funct3  out  3  to memory funct3
- mem_addr  out  6  to memory addr
- mem_wdata  out  32  to memory data_in
- mem_rdata  in  32  from memory data_out (combinational read)

Behaviour:
- Reset (async): if_rvalid=0, d_rvalid=0, if_rdata=0, d_rdata=0, starve_cnt=0, resp_state=NONE. A pending response is discarded; no rvalid follows reset.
- d_req = d_read | d_write. If both are high, the request is a write and the read is ignored.
- Grant rule, combinational:
  - only one requester active: that requester wins
  - both active: data wins unless starve_cnt == STARVE_LIMIT, then fetch wins
  - no requests: no grant, all mem_* strobes 0
- starve_cnt, on each clock edge:
  - clear if fetch is granted or if_req=0
  - otherwise increment if if_req=1 and fetch is denied
  - saturate at STARVE_LIMIT
- Fetch grant drives: mem_read=1, mem_write=0, mem_funct3=3'b010, mem_addr=if_addr[7:2].
- Data grant drives:
  - mem_addr = mapped data word
  - mem_funct3 = d_funct3
  - mem_read = d_read & ~d_write
  - mem_write = d_write
  - mem_wdata = d_wdata (always driven from d_wdata)
- Store completes at that clock edge inside memory. No d_rvalid for stores.
- resp_state FSM, registered: NONE, IF_RESP, D_RESP. Next state is IF_RESP on a fetch grant, D_RESP on a load grant, otherwise NONE.
- On a grant, mem_rdata is captured into if_rdata or d_rdata at that same edge. rvalid is high for exactly the next cycle, decoded from resp_state.
- Latency: request granted in cycle N, data valid in cycle N+1.
- Rdata registers hold their last value when rvalid=0.
- Requesters hold req/addr until they see their gnt. Ungranted requests have no side effects.
- Address wrap: all word indices are taken modulo 64. No error is raised.

Optional Feature:
- Macro: MISALIGN_CHECK_EN
- Defined: a data request is misaligned when LH/LHU/SH has d_addr[0]=1, or LW/SW has d_addr[1:0]!=0.
  - A misaligned request is granted (d_gnt=1) but mem_read and mem_write stay 0.
  - Extra output port d_misalign (1 bit, registered, reset 0) pulses in cycle N+1.
  - d_rvalid stays 0 for that request.
- Not defined: the d_misalign port is absent. Low address bits are ignored and the access proceeds normally.

Decomposition:
- Shared package mem_arb_pkg holds:
  - resp_state enum {NONE, IF_RESP, D_RESP}
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU
  - MEM_WORDS=64
- No sub-module; the grant logic, counter and FSM stay in one module.

Test Plan:
- if_req=1, if_addr=0x4, no data request -> cycle 0: if_gnt=1, mem_addr=1. Cycle 1: if_rvalid=1, if_rdata=mem[1].
- Load: d_read=1, funct3=010, d_addr=0x4, with if_req=1 -> d_gnt=1, if_gnt=0, mem_addr=54. Next cycle: d_rvalid=1, d_rdata=9. Fetch is granted in the following cycle.
- Store: d_write=1, funct3=010, d_addr=0xC, d_wdata=34 -> mem_write=1, mem_addr=56. A later load at 0xC returns 34 and d_rvalid never pulses for the store.
- Starvation: continuous d_read and if_req with STARVE_LIMIT=3 -> d_gnt for 3 cycles, if_gnt in cycle 4, then d_gnt resumes. The pattern repeats every 4 cycles.
- Reset: assert rst asynchronously in the cycle after a load grant -> d_rvalid drops to 0 immediately and starve_cnt=0. After release, the first grant behaves as from reset.
- MISALIGN_CHECK_EN defined: d_read, funct3=010, d_addr=0x6 -> mem_read=0 and next cycle d_misalign=1, d_rvalid=0.
